// File: rtl/trigger_wheel_sim_pkg.sv
// efi_trig_pkg: shared defaults and helpers for the crank trigger-wheel generator
package efi_trig_pkg;
  localparam int TEETH_DEF = 36;
  localparam int MISSING_DEF = 1;
  localparam int PERIOD_W_DEF = 16;
  localparam int CAM_TOOTH_DEF = 5;
  localparam int MIN_PERIOD = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/trigger_wheel_sim_if.sv
// trigger_wheel_sim_if: run control in, synthesised crank pattern out
interface trigger_wheel_sim_if import efi_trig_pkg::*; #(
  parameter int TEETH = TEETH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) ();
  logic en;
  logic [PERIOD_W-1:0] tooth_period;
  logic vr_out;
  logic cam_out;
  logic [clog2(TEETH)-1:0] tooth_idx;
  logic rev_strobe;
  logic [PERIOD_W-1:0] period_active;
  modport master (output en, tooth_period, input vr_out, cam_out, tooth_idx, rev_strobe, period_active);
  modport slave (input en, tooth_period, output vr_out, cam_out, tooth_idx, rev_strobe, period_active);
endinterface

// File: rtl/trigger_wheel_sim_tooth_timer.sv
// tooth_timer: per-tooth cycle counter whose period only reloads on clear or at a flagged wrap
module tooth_timer import efi_trig_pkg::*; #(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                run_i,
  input  logic                load_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic [PERIOD_W-1:0] cnt_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic                tc_o
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  assign tc_o = cnt_q == period_q - PERIOD_W'(1);
  always_comb begin
    cnt_d = clr_i ? '0 : !run_i ? cnt_q : tc_o ? '0 : cnt_q + PERIOD_W'(1);
    period_d = (clr_i || (run_i && tc_o && load_i)) ? period_i : period_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      period_q <= PERIOD_W'(MIN_PERIOD);
    end else begin
      cnt_q <= cnt_d;
      period_q <= period_d;
    end
  end
  assign cnt_o = cnt_q;
  assign period_o = period_q;
endmodule

// File: rtl/trigger_wheel_sim.sv
// trigger_wheel_sim: N-minus-M missing-tooth crank pattern generator with rev strobe and tooth index
// Define TRIGGER_CAM_OUT_EN to add the every-other-revolution cam pulse; otherwise cam_out is 0.
module trigger_wheel_sim import efi_trig_pkg::*; #(
  parameter int TEETH = TEETH_DEF,
  parameter int MISSING = MISSING_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int CAM_TOOTH = CAM_TOOTH_DEF
) (
  input logic clk,
  input logic reset,
  trigger_wheel_sim_if.slave bus
);
  localparam int TW = clog2(TEETH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [TW-1:0] LAST = TW'(TEETH - 1);
  localparam logic [TW-1:0] LIVE = TW'(TEETH - MISSING);
  if (TEETH < 3 || MISSING < 1 || MISSING > TEETH - 2 || CAM_TOOTH < 0 || CAM_TOOTH >= TEETH - MISSING) begin : g_bad_cfg
    $error("trigger_wheel_sim: illegal TEETH/MISSING/CAM_TOOTH combination");
  end
  logic [0:0] state_q, state_d;
  logic [TW-1:0] tooth_q, tooth_d, idx_q, idx_d;
  logic [PERIOD_W-1:0] cnt, period, eff_period;
  logic tc, adv, wrap;
  logic vr_q, vr_d, rev_q, rev_d;
  assign eff_period = bus.tooth_period < PERIOD_W'(MIN_PERIOD) ? PERIOD_W'(MIN_PERIOD) : bus.tooth_period;
  // The first enabled edge only arms RUN; counting starts on the edge after.
  assign adv = bus.en && state_q == RUN;
  assign wrap = adv && tc && tooth_q == LAST;
  tooth_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr_i(!bus.en),
    .run_i(adv),
    .load_i(tooth_q == LAST),
    .period_i(eff_period),
    .cnt_o(cnt),
    .period_o(period),
    .tc_o(tc)
  );
  always_comb begin
    state_d = bus.en ? RUN : IDLE;
    tooth_d = !bus.en ? '0 : !(adv && tc) ? tooth_q : wrap ? '0 : tooth_q + TW'(1);
    vr_d = adv && tooth_q < LIVE && cnt < (period >> 1);
    rev_d = adv && cnt == '0 && tooth_q == '0;
    idx_d = adv ? tooth_q : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tooth_q <= '0;
      vr_q <= 1'b0;
      rev_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      tooth_q <= tooth_d;
      vr_q <= vr_d;
      rev_q <= rev_d;
      idx_q <= idx_d;
    end
  end
`ifdef TRIGGER_CAM_OUT_EN
  localparam logic [TW-1:0] CAM = TW'(CAM_TOOTH);
  logic parity_q, parity_d, cam_q, cam_d;
  assign parity_d = !bus.en ? 1'b0 : wrap ? !parity_q : parity_q;
  assign cam_d = adv && !parity_q && tooth_q == CAM;
  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
      cam_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
      cam_q <= cam_d;
    end
  end
  assign bus.cam_out = cam_q;
`else
  assign bus.cam_out = 1'b0;
`endif
  assign bus.vr_out = vr_q;
  assign bus.rev_strobe = rev_q;
  assign bus.tooth_idx = idx_q;
  assign bus.period_active = period;
endmodule
